// File: rtl/fp16_mul_arbiter.sv
// fp16_mul_arbiter: round-robin sharing of one pipelined fp16 multiplier.
// Tags ride alongside the multiplier so each product returns to its owner.
module fp16_mul_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 16,
  parameter int M_LAT = 6,
  parameter int TW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*DW-1:0] a_flat,
  input  logic [NREQ*DW-1:0] b_flat,
  output logic [NREQ-1:0]    gnt,
  output logic [DW-1:0]      mul_a,
  output logic [DW-1:0]      mul_b,
  output logic               mul_valid_in,
  input  logic [DW-1:0]      mul_result,
  input  logic               mul_valid_out,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               busy,
  output logic               err
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(M_LAT + 2);

  logic [PW-1:0] ptr;
  logic [PW-1:0] ptr_nxt;
  logic [TW-1:0] gidx;
  logic          accept;
  logic [DW-1:0] sel_a;
  logic [DW-1:0] sel_b;
  logic [M_LAT:0] stg_vld;
  logic [TW-1:0]  stg_tag [M_LAT+1];
  logic [CW-1:0]  settle;
  logic           hit;

  // Round-robin search starting at ptr; first requester found wins.
  always_comb begin
    int idx;
    idx    = 0;
    gnt    = '0;
    gidx   = '0;
    accept = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (en && !accept && req[idx]) begin
        gnt[idx] = 1'b1;
        gidx     = TW'(idx);
        accept   = 1'b1;
      end
    end
  end

  // Pointer moves just past the winner, holds otherwise.
  always_comb begin
    ptr_nxt = ptr;
    if (accept) begin
      if (int'(gidx) == NREQ - 1) ptr_nxt = '0;
      else ptr_nxt = PW'(int'(gidx) + 1);
    end
  end

  // Operand mux driven by the one-hot grant.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        sel_a = a_flat[i*DW +: DW];
        sel_b = b_flat[i*DW +: DW];
      end
    end
  end

  // Pointer and multiplier operand registers; operands hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      mul_a <= '0;
      mul_b <= '0;
    end else begin
      ptr <= ptr_nxt;
      if (accept) begin
        mul_a <= sel_a;
        mul_b <= sel_b;
      end
    end
  end

  // Tag pipeline; stage 0 doubles as the multiplier valid_in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stg_vld <= '0;
      for (int k = 0; k <= M_LAT; k++) stg_tag[k] <= '0;
    end else begin
      stg_vld    <= {stg_vld[M_LAT-1:0], accept};
      stg_tag[0] <= gidx;
      for (int k = 1; k <= M_LAT; k++) stg_tag[k] <= stg_tag[k-1];
    end
  end

  assign mul_valid_in = stg_vld[0];
  assign hit          = stg_vld[M_LAT] & mul_valid_out;

  // Registered response strobe routed by the emerging tag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++)
        rsp_valid[i] <= hit && (stg_tag[M_LAT] == TW'(i));
      if (hit) rsp_data <= mul_result;
    end
  end

  // Settle window hides stale output of the unreset multiplier.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settle <= CW'(M_LAT + 1);
      err    <= 1'b0;
    end else if (settle != '0) begin
      settle <= settle - CW'(1);
    end else if (stg_vld[M_LAT] != mul_valid_out) begin
      err <= 1'b1;
    end
  end

  assign busy = (|stg_vld) | (|rsp_valid);

endmodule

// File: tb/tb_fp16_mul_arbiter.sv
// tb_fp16_mul_arbiter: directed bench with multiplier model and
// a scoreboard queue matching responses to accepted requests.
module tb_fp16_mul_arbiter;

  localparam int NREQ  = 4;
  localparam int DW    = 16;
  localparam int M_LAT = 6;
  localparam int TW    = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               en;
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] a_flat;
  logic [NREQ*DW-1:0] b_flat;
  logic [NREQ-1:0]    gnt;
  logic [DW-1:0]      mul_a;
  logic [DW-1:0]      mul_b;
  logic               mul_valid_in;
  logic [DW-1:0]      mul_result;
  logic               mul_valid_out;
  logic [NREQ-1:0]    rsp_valid;
  logic [DW-1:0]      rsp_data;
  logic               busy;
  logic               err;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  logic drop   = 1'b0;

  typedef struct {
    int          idx;
    logic [15:0] d;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t e;

  fp16_mul_arbiter #(
    .NREQ(NREQ), .DW(DW), .M_LAT(M_LAT), .TW(TW)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .a_flat(a_flat), .b_flat(b_flat), .gnt(gnt),
    .mul_a(mul_a), .mul_b(mul_b),
    .mul_valid_in(mul_valid_in),
    .mul_result(mul_result),
    .mul_valid_out(mul_valid_out),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Truncating fp16 multiply, normal operands only.
  function automatic logic [15:0] fmul(input logic [15:0] a,
                                       input logic [15:0] b);
    logic [21:0] p;
    int          ex;
    logic [9:0]  m;
    p  = {11'b0, 1'b1, a[9:0]} * {11'b0, 1'b1, b[9:0]};
    ex = int'(a[14:10]) + int'(b[14:10]) - 15;
    if (p[21]) begin
      ex = ex + 1;
      m  = p[20:11];
    end else begin
      m  = p[19:10];
    end
    return {a[15] ^ b[15], 5'(ex), m};
  endfunction

  // Multiplier model: fixed latency, no reset.
  logic [M_LAT-1:0] pv = '0;
  logic [DW-1:0]    pr [M_LAT];

  always @(posedge clk) begin
    pv    <= {pv[M_LAT-2:0], mul_valid_in};
    pr[0] <= fmul(mul_a, mul_b);
    for (int k = 1; k < M_LAT; k++) pr[k] <= pr[k-1];
  end

  assign mul_valid_out = pv[M_LAT-1] & ~drop;
  assign mul_result    = pr[M_LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exv);
    checks++;
    assert (obs === exv) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic samp();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input logic [15:0] a,
                        input logic [15:0] b);
    a_flat[i*DW +: DW] = a;
    b_flat[i*DW +: DW] = b;
  endtask

  // Scoreboard: push on accept, pop and compare on response.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
    end else begin
      chk("gnt_onehot", 32'($onehot0(gnt)), 32'd1);
      if (|(gnt & req)) begin
        for (int i = 0; i < NREQ; i++) begin
          if (gnt[i]) begin
            e.idx = i;
            e.d   = fmul(a_flat[i*DW +: DW], b_flat[i*DW +: DW]);
            e.cyc = cyc + M_LAT + 2;
            q.push_back(e);
          end
        end
      end
      if (|rsp_valid) begin
        if (q.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 32'd0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(1 << e.idx));
          chk("rsp_data", 32'(rsp_data), 32'(e.d));
          chk("rsp_lat", 32'(cyc), 32'(e.cyc));
        end
      end
    end
  end

  initial begin
    rst    = 1'b1;
    en     = 1'b0;
    req    = '0;
    a_flat = '0;
    b_flat = '0;

    // reset state
    repeat (3) tick();
    samp();
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_mul_a", 32'(mul_a), 32'd0);
    chk("rst_mul_b", 32'(mul_b), 32'd0);
    chk("rst_vin", 32'(mul_valid_in), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_data", 32'(rsp_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    tick();
    rst = 1'b0;
    repeat (M_LAT + 2) tick();

    // single request 1.0 * 2.0
    en  = 1'b1;
    req = 4'b0001;
    set_op(0, 16'h3C00, 16'h4000);
    samp();
    chk("single_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    samp();
    chk("single_vin", 32'(mul_valid_in), 32'd1);
    chk("single_mul_a", 32'(mul_a), 32'h3C00);
    chk("single_mul_b", 32'(mul_b), 32'h4000);
    chk("single_busy", 32'(busy), 32'd1);
    tick();
    samp();
    chk("idle_vin", 32'(mul_valid_in), 32'd0);
    chk("idle_hold_a", 32'(mul_a), 32'h3C00);
    repeat (8) tick();

    // bring ptr to 0 by granting requester 3
    req = 4'b1000;
    set_op(3, 16'h4800, 16'h3E00);
    samp();
    chk("ptr_gnt3", 32'(gnt), 32'h8);

    // all four requesting, round-robin order
    for (int k = 0; k < 8; k++) begin
      tick();
      req = 4'b1111;
      set_op(0, 16'h3C00, 16'h3C00 + 16'(k * 64));
      set_op(1, 16'h4000, 16'h3C40 + 16'(k * 64));
      set_op(2, 16'h4400, 16'h3C80 + 16'(k * 64));
      set_op(3, 16'h4800, 16'h3CC0 + 16'(k * 64));
      samp();
      chk("rr_gnt", 32'(gnt), 32'(1 << (k % 4)));
    end

    // fairness between 0 and 3
    for (int k = 0; k < 4; k++) begin
      tick();
      req = 4'b1001;
      samp();
      chk("fair_gnt", 32'(gnt), (k % 2 == 0) ? 32'h1 : 32'h8);
    end

    // three in flight then en=0
    for (int k = 0; k < 3; k++) begin
      tick();
      req = 4'b1111;
      samp();
      chk("drain_gnt", 32'(gnt), 32'(1 << k));
    end
    tick();
    en = 1'b0;
    samp();
    chk("en0_gnt", 32'(gnt), 32'd0);
    repeat (7) tick();
    samp();
    chk("drain_last_rsp", 32'(rsp_valid), 32'h4);
    chk("drain_busy_hi", 32'(busy), 32'd1);
    tick();
    req = '0;
    samp();
    chk("drain_busy_lo", 32'(busy), 32'd0);

    // dropped multiplier valid -> sticky err
    tick();
    en  = 1'b1;
    req = 4'b0001;
    set_op(0, 16'h4000, 16'h4200);
    samp();
    chk("drop_gnt", 32'(gnt), 32'h1);
    tick();
    req = '0;
    repeat (6) tick();
    drop = 1'b1;
    tick();
    drop = 1'b0;
    samp();
    chk("drop_err", 32'(err), 32'd1);
    chk("drop_no_rsp", 32'(rsp_valid), 32'd0);
    #1;
    chk("drop_q", 32'(q.size()), 32'd1);
    if (q.size() > 0) void'(q.pop_front());
    repeat (3) tick();
    samp();
    chk("err_sticky", 32'(err), 32'd1);
    tick();
    rst = 1'b1;
    samp();
    chk("err_clr", 32'(err), 32'd0);
    chk("rst_busy2", 32'(busy), 32'd0);
    tick();
    rst = 1'b0;
    repeat (M_LAT + 3) tick();

    // reset three cycles after an accept
    req = 4'b0010;
    set_op(1, 16'h3C00, 16'h4400);
    samp();
    chk("rmid_gnt", 32'(gnt), 32'h2);
    tick();
    req = '0;
    repeat (2) tick();
    rst = 1'b1;
    samp();
    tick();
    rst = 1'b0;
    repeat (4) tick();
    samp();
    chk("rmid_no_rsp", 32'(rsp_valid), 32'd0);
    chk("rmid_busy", 32'(busy), 32'd0);
    repeat (4) tick();
    samp();
    chk("rmid_err", 32'(err), 32'd0);

    tick();
    samp();
    chk("sb_empty", 32'(q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
